udc_bus_master: RTL and testbench

- Host-side bus master for the 8-bit up/down counter peripheral.
- Accepts one "program and run" request: PLR, ULR, LLR and CCR values plus a launch handshake.
- Writes the four registers over the ncs/nwr/nrd/A1:A0/Din bus, reads them back for verification, issues the start pulse, then waits for end-of-cycle (ec).
- Reports completion and a status code to the host; sits between the system controller and the counter.

---
 rtl/udc_bus_master.sv | 247 ++++++++++++++++++++++++
 tb/tb_udc_bus_master.sv | 301 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/udc_bus_master.sv
// udc_bus_master: programs, optionally verifies, and launches the 8-bit up/down counter.
// Define UDC_MASTER_READBACK_EN to include the TURN/RD0..RD3 readback phase and mismatch reporting.
module udc_bus_master #(
  parameter int START_CYCLES = 1,  // start pulse width in cycles: 1 or 2
  parameter int TIMEOUT_W    = 12
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       launch_valid,
  output logic       launch_ready,
  input  logic [7:0] plr_in,
  input  logic [7:0] ulr_in,
  input  logic [7:0] llr_in,
  input  logic [7:0] ccr_in,
  output logic       busy,
  output logic       done,
  output logic [1:0] status,
  output logic [1:0] mismatch_addr,
  inout  wire  [7:0] din,
  output logic       ncs,
  output logic       nwr,
  output logic       nrd,
  output logic       a0,
  output logic       a1,
  output logic       start,
  input  logic       err,
  input  logic       ec,
  input  logic       dir
);

  typedef enum logic [2:0] {
    S_IDLE, S_WR, S_TURN, S_RD, S_CHK, S_START, S_WAIT, S_DONE
  } state_e;

  typedef enum logic [1:0] {
    ST_OK = 2'b00, ST_MISMATCH = 2'b01, ST_CNT_ERR = 2'b10, ST_TIMEOUT = 2'b11
  } status_e;

  // Watchdog value whose increment reaches all-ones: WAIT_EC then lasts 2**TIMEOUT_W-1 cycles.
  localparam logic [TIMEOUT_W-1:0] WD_LAST = {{(TIMEOUT_W-1){1'b1}}, 1'b0};

  state_e               state_q, state_d;
  logic [1:0]           idx_q, idx_d;
  logic                 st_cnt_q, st_cnt_d;
  logic [TIMEOUT_W-1:0] wdog_q, wdog_d;
  status_e              status_q, status_d;
  logic [1:0]           mm_addr_q, mm_addr_d;
  logic [7:0]           regs_q [4];
  logic                 launch;
  logic                 start_last;

  logic       ncs_q, ncs_d, nwr_q, nwr_d, nrd_q, nrd_d;
  logic       start_q, start_d, drive_q, drive_d;
  logic [1:0] addr_q, addr_d;

`ifdef UDC_MASTER_READBACK_EN
  logic       mm_seen_q, mm_seen_d;
  logic [1:0] mm_idx_q, mm_idx_d;
`else
  logic unused_din;
  assign unused_din = ^din;
`endif

  logic unused_dir;
  assign unused_dir = dir;

  assign launch     = (state_q == S_IDLE) && launch_valid;
  assign start_last = (START_CYCLES == 1) || st_cnt_q;

  always_comb begin
    // NOTE: every variable gets a default first so no path through the case infers a latch.
    state_d   = state_q;
    idx_d     = idx_q;
    st_cnt_d  = 1'b0;
    wdog_d    = '0;
    status_d  = status_q;
    mm_addr_d = mm_addr_q;
`ifdef UDC_MASTER_READBACK_EN
    mm_seen_d = mm_seen_q;
    mm_idx_d  = mm_idx_q;
`endif
    unique case (state_q)
      S_IDLE: begin
        if (launch) begin
          state_d   = S_WR;
          idx_d     = 2'd0;
          status_d  = ST_OK;
          mm_addr_d = 2'd0;
`ifdef UDC_MASTER_READBACK_EN
          mm_seen_d = 1'b0;
`endif
        end
      end
      S_WR: begin
        idx_d = idx_q + 2'd1;
        if (idx_q == 2'd3) begin
`ifdef UDC_MASTER_READBACK_EN
          state_d = S_TURN;
`else
          state_d = S_CHK;
`endif
        end
      end
`ifdef UDC_MASTER_READBACK_EN
      S_TURN: begin
        state_d = S_RD;
        idx_d   = 2'd0;
      end
      S_RD: begin
        idx_d = idx_q + 2'd1;
        // Only the lowest failing address is kept.
        if (!mm_seen_q && (din != regs_q[idx_q])) begin
          mm_seen_d = 1'b1;
          mm_idx_d  = idx_q;
        end
        if (idx_q == 2'd3) state_d = S_CHK;
      end
`endif
      S_CHK: begin
`ifdef UDC_MASTER_READBACK_EN
        if (mm_seen_q) begin
          state_d   = S_DONE;
          status_d  = ST_MISMATCH;
          mm_addr_d = mm_idx_q;
        end else
`endif
        if (regs_q[3] == 8'd0) begin
          state_d  = S_DONE;
          status_d = ST_OK;
        end else begin
          state_d = S_START;
        end
      end
      S_START: begin
        st_cnt_d = st_cnt_q + 1'b1;
        if (start_last) state_d = S_WAIT;
      end
      S_WAIT: begin
        wdog_d = wdog_q + 1'b1;
        if (ec) begin
          state_d  = S_DONE;
          status_d = ST_OK;
        end else if (err) begin
          state_d  = S_DONE;
          status_d = ST_CNT_ERR;
        end else if (wdog_q == WD_LAST) begin
          state_d  = S_DONE;
          status_d = ST_TIMEOUT;
        end
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // Bus strobes are decoded from the next state and registered, so no input reaches them combinationally.
  always_comb begin
    ncs_d   = 1'b1;
    nwr_d   = 1'b1;
    nrd_d   = 1'b1;
    start_d = 1'b0;
    drive_d = 1'b0;
    addr_d  = 2'd0;
    unique case (state_d)
      S_WR: begin
        ncs_d   = 1'b0;
        nwr_d   = 1'b0;
        drive_d = 1'b1;
        addr_d  = idx_d;
      end
      S_RD: begin
        ncs_d  = 1'b0;
        nrd_d  = 1'b0;
        addr_d = idx_d;
      end
      S_START: begin
        ncs_d   = 1'b0;
        start_d = 1'b1;
      end
      S_WAIT:  ncs_d = 1'b0;
      default: ;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q   <= S_IDLE;
      idx_q     <= 2'd0;
      st_cnt_q  <= 1'b0;
      wdog_q    <= '0;
      status_q  <= ST_OK;
      mm_addr_q <= 2'd0;
      ncs_q     <= 1'b1;
      nwr_q     <= 1'b1;
      nrd_q     <= 1'b1;
      start_q   <= 1'b0;
      drive_q   <= 1'b0;
      addr_q    <= 2'd0;
`ifdef UDC_MASTER_READBACK_EN
      mm_seen_q <= 1'b0;
      mm_idx_q  <= 2'd0;
`endif
    end else begin
      state_q   <= state_d;
      idx_q     <= idx_d;
      st_cnt_q  <= st_cnt_d;
      wdog_q    <= wdog_d;
      status_q  <= status_d;
      mm_addr_q <= mm_addr_d;
      ncs_q     <= ncs_d;
      nwr_q     <= nwr_d;
      nrd_q     <= nrd_d;
      start_q   <= start_d;
      drive_q   <= drive_d;
      addr_q    <= addr_d;
`ifdef UDC_MASTER_READBACK_EN
      mm_seen_q <= mm_seen_d;
      mm_idx_q  <= mm_idx_d;
`endif
    end
  end

  // NOTE: the value registers carry no reset; they are always loaded by the launch before being used.
  always_ff @(posedge clk) begin
    if (launch) begin
      regs_q[0] <= plr_in;
      regs_q[1] <= ulr_in;
      regs_q[2] <= llr_in;
      regs_q[3] <= ccr_in;
    end
  end

  assign din           = drive_q ? regs_q[addr_q] : 8'bz;
  assign ncs           = ncs_q;
  assign nwr           = nwr_q;
  assign nrd           = nrd_q;
  assign start         = start_q;
  assign a1            = addr_q[1];
  assign a0            = addr_q[0];
  assign launch_ready  = (state_q == S_IDLE);
  assign busy          = (state_q != S_IDLE);
  assign done          = (state_q == S_DONE);
  assign status        = status_q;
  assign mismatch_addr = mm_addr_q;

endmodule

// File: tb/tb_udc_bus_master.sv
// tb_udc_bus_master: randomized scoreboard bench for udc_bus_master with a behavioural counter model.
`timescale 1ns/1ps
module tb_udc_bus_master;

  localparam int S_CYC  = 2;
  localparam int TW     = 4;
  localparam int WD_CYC = (1 << TW) - 1;
`ifdef UDC_MASTER_READBACK_EN
  localparam int RB_CYC = 5;
  localparam bit RB     = 1'b1;
`else
  localparam int RB_CYC = 0;
  localparam bit RB     = 1'b0;
`endif

  logic       clk = 1'b0, reset = 1'b0, launch_valid = 1'b0;
  logic [7:0] plr_in = '0, ulr_in = '0, llr_in = '0, ccr_in = '0;
  logic       err = 1'b0, ec = 1'b0, dir = 1'b0;
  logic       launch_ready, busy, done, ncs, nwr, nrd, a0, a1, start;
  logic [1:0] status, mismatch_addr;
  wire  [7:0] din;

  udc_bus_master #(.START_CYCLES(S_CYC), .TIMEOUT_W(TW)) dut (
    .clk(clk), .reset(reset), .launch_valid(launch_valid), .launch_ready(launch_ready),
    .plr_in(plr_in), .ulr_in(ulr_in), .llr_in(llr_in), .ccr_in(ccr_in),
    .busy(busy), .done(done), .status(status), .mismatch_addr(mismatch_addr),
    .din(din), .ncs(ncs), .nwr(nwr), .nrd(nrd), .a0(a0), .a1(a1), .start(start),
    .err(err), .ec(ec), .dir(dir)
  );

  always #5 clk = ~clk;

  int passed = 0, total = 0;
  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input int act, input int exp);
    total++;
    if (act == exp) passed++;
    else $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
  endtask

  task automatic flag_fail(input string name);
    total++;
    $display("FAIL %s: got event, expected none (t=%0t)", name, $time);
  endtask

  // Counter peripheral model: register file with optional read corruption and a bus probe driver.
  logic [7:0] mem [4];
  logic [7:0] corrupt [4];
  logic       probe = 1'b0;
  logic [1:0] bus_addr;
  logic       tb_en;
  logic [7:0] tb_val;
  assign bus_addr = {a1, a0};
  always_comb begin
    tb_en  = probe || (!ncs && !nrd);
    tb_val = probe ? 8'h3C : (mem[bus_addr] ^ corrupt[bus_addr]);
  end
  assign din = tb_en ? tb_val : 8'bz;

  // ec/err are raised in the chosen WAIT_EC cycle, counted from the edge where start falls.
  int   ec_at = 0, err_at = 0, wait_cnt = 0;
  logic start_prev = 1'b0;
  always begin
    @(posedge clk);
    #1;
    if (!reset) begin
      wait_cnt   = 0;
      start_prev = 1'b0;
    end else begin
      if (start_prev && !start) wait_cnt = 1;
      else if (wait_cnt != 0) wait_cnt++;
      start_prev = start;
      if (done) wait_cnt = 0;
    end
    ec  = (wait_cnt != 0) && (wait_cnt == ec_at);
    err = (wait_cnt != 0) && (wait_cnt == err_at);
  end

  typedef struct {
    int status;
    int mm;
    int lat;
    int starts;
    int reads;
    int launch_cyc;
  } exp_t;
  typedef struct {
    int addr;
    int data;
  } wr_t;
  exp_t exp_q[$];
  wr_t  wr_q[$];

  // Monitor: checks write cycles as they appear and each done pulse against the scoreboard.
  int n_reads = 0, n_starts = 0, n_viol = 0;
  always @(negedge clk) begin
    exp_t e;
    wr_t  w;
    if (!reset) begin
      n_reads = 0; n_starts = 0; n_viol = 0;
    end else begin
      if (!nwr && !nrd) n_viol++;
      if (!ncs && !nrd) n_reads++;
      if (start) n_starts++;
      if (!ncs && !nwr) begin
        mem[bus_addr] = din;
        if (wr_q.size() == 0) flag_fail("unexpected_write");
        else begin
          w = wr_q.pop_front();
          check("wr_addr", int'(bus_addr), w.addr);
          check("wr_data", int'(din), w.data);
        end
      end
      if (done) begin
        if (exp_q.size() == 0) flag_fail("unexpected_done");
        else begin
          e = exp_q.pop_front();
          check("status", int'(status), e.status);
          check("mismatch_addr", int'(mismatch_addr), e.mm);
          check("latency", cyc - e.launch_cyc + 1, e.lat);
          check("start_cycles", n_starts, e.starts);
          check("read_cycles", n_reads, e.reads);
          check("bus_conflict", n_viol, 0);
          check("busy_at_done", int'(busy), 1);
        end
        n_reads = 0; n_starts = 0; n_viol = 0;
      end
    end
  end

  // Reference model: expected outcome of one launch from the sequencing rules.
  function automatic exp_t predict(input logic [7:0] c, input int e_at, input int r_at);
    exp_t e;
    int first_bad = -1, tec, terr, n;
    if (RB) for (int k = 0; k < 4; k++) if (corrupt[k] != 8'd0 && first_bad < 0) first_bad = k;
    e.reads = RB ? 4 : 0;
    e.mm = 0; e.starts = 0; e.launch_cyc = 0;
    if (first_bad >= 0) begin
      e.status = 1; e.mm = first_bad; e.lat = 4 + RB_CYC + 2;
    end else if (c == 8'd0) begin
      e.status = 0; e.lat = 4 + RB_CYC + 2;
    end else begin
      tec  = (e_at != 0) ? e_at : 1000;
      terr = (r_at != 0) ? r_at : 1000;
      n = WD_CYC;
      if (tec < n) n = tec;
      if (terr < n) n = terr;
      e.status = (tec == n) ? 0 : (terr == n) ? 2 : 3;
      e.starts = S_CYC;
      e.lat    = 4 + RB_CYC + 1 + S_CYC + n + 1;
    end
    return e;
  endfunction

  task automatic flush_and_reset();
    reset = 1'b0;
    repeat (2) @(negedge clk);
    exp_q.delete();
    wr_q.delete();
    launch_valid = 1'b0;
    reset = 1'b1;
    @(negedge clk);
  endtask

  task automatic launch(input logic [7:0] p, u, l, c, input int e_at, r_at,
                        input int cidx, input logic [7:0] cx, input bit hold_valid,
                        input bit push_exp);
    exp_t e;
    bit   got;
    for (int k = 0; k < 4; k++) corrupt[k] = 8'd0;
    if (cidx >= 0) corrupt[cidx] = cx;
    ec_at = e_at;
    err_at = r_at;
    e = predict(c, e_at, r_at);
    wr_q.push_back('{0, int'(p)});
    wr_q.push_back('{1, int'(u)});
    wr_q.push_back('{2, int'(l)});
    wr_q.push_back('{3, int'(c)});
    plr_in = p; ulr_in = u; llr_in = l; ccr_in = c;
    launch_valid = 1'b1;
    got = 1'b0;
    for (int i = 0; i < 20 && !got; i++) begin
      if (launch_ready) got = 1'b1;
      else @(negedge clk);
    end
    if (!got) begin
      check("launch_ready_timeout", 0, 1);
      flush_and_reset();
      return;
    end
    @(posedge clk);
    #1;
    e.launch_cyc = cyc;
    if (push_exp) exp_q.push_back(e);
    if (hold_valid) begin
      plr_in = ~p; ulr_in = ~u; llr_in = ~l; ccr_in = ~c;
    end else begin
      launch_valid = 1'b0;
    end
  endtask

  task automatic run(input logic [7:0] p, u, l, c, input int e_at, r_at,
                     input int cidx, input logic [7:0] cx, input bit hold_valid);
    bit seen;
    launch(p, u, l, c, e_at, r_at, cidx, cx, hold_valid, 1'b1);
    seen = 1'b0;
    for (int i = 0; i < 80 && !seen; i++) begin
      @(negedge clk);
      if (done) seen = 1'b1;
    end
    launch_valid = 1'b0;
    if (!seen) begin
      check("done_timeout", 0, 1);
      flush_and_reset();
    end else begin
      @(negedge clk);
    end
  endtask

  task automatic reset_midway();
    bit hit;
    launch(8'd10, 8'd15, 8'd5, 8'd2, 3, 0, -1, 8'd0, 1'b0, 1'b0);
    hit = 1'b0;
    for (int i = 0; i < 30 && !hit; i++) begin
      @(negedge clk);
      if (RB ? (!nrd && bus_addr == 2'd2) : (!nwr && bus_addr == 2'd2)) hit = 1'b1;
    end
    check("reached_mid_phase", int'(hit), 1);
    #2;
    reset = 1'b0;
    probe = 1'b1;
    #1;
    check("rst_mid_ncs", int'(ncs), 1);
    check("rst_mid_nwr", int'(nwr), 1);
    check("rst_mid_nrd", int'(nrd), 1);
    check("rst_mid_busy", int'(busy), 0);
    check("rst_mid_din_released", int'(din), 8'h3C);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check("rst_mid_no_done", int'(done), 0);
    end
    probe = 1'b0;
    exp_q.delete();
    wr_q.delete();
    reset = 1'b1;
    @(negedge clk);
  endtask

  initial begin
    logic [7:0] p, u, l, c;
    int cidx;
    for (int k = 0; k < 4; k++) begin
      mem[k] = 8'd0;
      corrupt[k] = 8'd0;
    end
    repeat (3) @(negedge clk);
    check("rst_launch_ready", int'(launch_ready), 1);
    check("rst_busy", int'(busy), 0);
    check("rst_done", int'(done), 0);
    check("rst_status", int'(status), 0);
    check("rst_mismatch_addr", int'(mismatch_addr), 0);
    check("rst_ncs", int'(ncs), 1);
    check("rst_nwr", int'(nwr), 1);
    check("rst_nrd", int'(nrd), 1);
    check("rst_start", int'(start), 0);
    check("rst_addr", int'(bus_addr), 0);
    reset = 1'b1;
    @(negedge clk);

    run(8'd10,  8'd15,  8'd5,   8'd2, 3,  0,  -1, 8'h00, 1'b0);  // nominal
    run(8'd5,   8'd5,   8'd5,   8'd1, 1,  0,  -1, 8'h00, 1'b0);  // equal limits, fastest ec
    run(8'h10,  8'h15,  8'h05,  8'd2, 2,  0,   1, 8'h03, 1'b0);  // ULR reads back 0x16
    run(8'd20,  8'd15,  8'd5,   8'd1, 0,  1,  -1, 8'h00, 1'b0);  // out-of-range preload, err
    run(8'd7,   8'd9,   8'd3,   8'd4, 0,  0,  -1, 8'h00, 1'b0);  // watchdog timeout
    run(8'd7,   8'd9,   8'd3,   8'd0, 2,  0,  -1, 8'h00, 1'b0);  // ccr=0: no start
    run(8'd1,   8'd2,   8'd0,   8'd3, 2,  2,  -1, 8'h00, 1'b0);  // ec beats err
    run(8'd1,   8'd2,   8'd0,   8'd3, 0,  15, -1, 8'h00, 1'b0);  // err beats timeout
    run(8'd1,   8'd2,   8'd0,   8'd3, 15, 0,  -1, 8'h00, 1'b0);  // ec beats timeout
    run(8'd9,   8'd12,  8'd2,   8'd5, 4,  0,   3, 8'h80, 1'b1);  // launch_valid held while busy
    reset_midway();
    run(8'd33,  8'd40,  8'd30,  8'd6, 2,  0,  -1, 8'h00, 1'b0);  // accepted after reset

    for (int i = 0; i < 24; i++) begin
      p = 8'($urandom);
      u = 8'($urandom);
      l = 8'($urandom);
      c = ($urandom_range(0, 3) == 0) ? 8'd0 : 8'($urandom);
      cidx = ($urandom_range(0, 2) == 0) ? int'($urandom_range(0, 3)) : -1;
      run(p, u, l, c, int'($urandom_range(0, 16)), int'($urandom_range(0, 16)),
          cidx, 8'($urandom_range(1, 255)), 1'($urandom_range(0, 1)));
    end

    check("scoreboard_empty", exp_q.size(), 0);
    check("write_queue_empty", wr_q.size(), 0);
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
